// File: rtl/mem_resp_if.sv
// Bus bundle between a CPU-side requester and the mem_resp memory responder.
// The master drives the request fields; the slave answers with ok and read data.
interface mem_resp_if;
   logic [3:0]  nb;
   logic [15:0] ad;
   logic [15:0] dt_in;
   logic        r;
   logic        w;
   logic        ok;
   logic [15:0] dt_out;

   modport master (
      output nb, ad, dt_in, r, w,
      input  ok, dt_out
   );

   modport slave (
      input  nb, ad, dt_in, r, w,
      output ok, dt_out
   );
endinterface

// File: rtl/mem_resp.sv
// Memory responder: serves mapped read/write requests from an internal word RAM
// after LAT cycles and answers with a four-phase ok handshake.
module mem_resp #(
   parameter logic [3:0]  NB  = 4'd0,
   parameter int unsigned AW  = 12,
   parameter int unsigned LAT = 2
) (
   input  logic       clk_sys,
   input  logic       rst_,
   mem_resp_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   localparam logic [3:0] CntInit = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

   state_e       state_q;
   logic [3:0]   cnt_q;
   logic         ok_q;
   logic [15:0]  dt_q;
   logic [15:0]  mem_q [2**AW];

   logic          req_rd;
   logic          req_wr;
   logic          req_any;
   logic          mapped;
   logic          access;
   logic          wr_en;
   logic [AW-1:0] idx;

   always_comb begin
      req_rd  = bus.r & ~bus.w;
      req_wr  = bus.w & ~bus.r;
      req_any = bus.r | bus.w;
      // Both strobes high is a protocol violation and never counts as mapped.
      mapped  = (req_rd | req_wr) && (bus.nb == NB) &&
                ((32'(bus.ad) >> AW) == 32'd0);
      idx     = bus.ad[AW-1:0];
      access  = 1'b0;
      unique case (state_q)
         StIdle:  access = mapped && (LAT == 0);
         StWait:  access = req_any && (cnt_q == 4'd0);
         default: access = 1'b0;
      endcase
      // Reset on the same edge overrides the write.
      wr_en = rst_ && access && req_wr;
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) begin
         mem_q[idx] <= bus.dt_in;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ok_q    <= 1'b0;
         dt_q    <= 16'h0000;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (access) begin
                  state_q <= StAck;
                  ok_q    <= 1'b1;
                  dt_q    <= req_rd ? mem_q[idx] : 16'h0000;
               end else if (mapped) begin
                  state_q <= StWait;
                  cnt_q   <= CntInit;
               end
            end
            StWait: begin
               if (!req_any) begin
                  state_q <= StIdle;
                  cnt_q   <= 4'd0;
               end else if (access) begin
                  state_q <= StAck;
                  ok_q    <= 1'b1;
                  dt_q    <= req_rd ? mem_q[idx] : 16'h0000;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StAck: begin
               if (!req_any) begin
                  state_q <= StIdle;
                  ok_q    <= 1'b0;
                  dt_q    <= 16'h0000;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= 4'd0;
               ok_q    <= 1'b0;
               dt_q    <= 16'h0000;
            end
         endcase
      end
   end

   assign bus.ok     = ok_q;
   assign bus.dt_out = dt_q;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: cycle-by-cycle vector tables for LAT=2 and LAT=0 instances
// plus hand-written loops for unmapped and both-strobe requests.
module tb_mem_resp;

   typedef struct {
      logic        rst;
      logic        r;
      logic        w;
      logic [3:0]  nb;
      logic [15:0] ad;
      logic [15:0] dt;
      logic        exp_ok;
      logic [15:0] exp_dt;
   } vec_t;

   logic clk_sys = 1'b0;
   logic rst_a   = 1'b0;
   logic rst_b   = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_sys = ~clk_sys;

   mem_resp_if ia ();
   mem_resp_if ib ();

   mem_resp #(.NB(4'd0), .AW(12), .LAT(2)) u_dut_a (
      .clk_sys (clk_sys),
      .rst_    (rst_a),
      .bus     (ia.slave)
   );

   mem_resp #(.NB(4'd0), .AW(12), .LAT(0)) u_dut_b (
      .clk_sys (clk_sys),
      .rst_    (rst_b),
      .bus     (ib.slave)
   );

   vec_t va[$];
   vec_t vb[$];

   function automatic vec_t v(logic rst, logic r, logic w, logic [3:0] nb, logic [15:0] ad,
                              logic [15:0] dt, logic eok, logic [15:0] edt);
      vec_t x;
      x.rst = rst; x.r = r; x.w = w; x.nb = nb; x.ad = ad; x.dt = dt;
      x.exp_ok = eok; x.exp_dt = edt;
      return x;
   endfunction

   task automatic check(input string nm, input logic aok, input logic eok,
                        input logic [15:0] adt, input logic [15:0] edt);
      checks++;
      if (aok !== eok || adt !== edt) begin
         failures++;
         $display("FAIL %s: got ok=%b dt_out=%h, want ok=%b dt_out=%h", nm, aok, adt, eok, edt);
      end
   endtask

   task automatic drive_a(input logic rst, input logic r, input logic w, input logic [3:0] nb,
                          input logic [15:0] ad, input logic [15:0] dt);
      rst_a = rst; ia.r = r; ia.w = w; ia.nb = nb; ia.ad = ad; ia.dt_in = dt;
   endtask

   task automatic apply_a(input vec_t x, input string nm);
      drive_a(x.rst, x.r, x.w, x.nb, x.ad, x.dt);
      @(posedge clk_sys); #1;
      check(nm, ia.ok, x.exp_ok, ia.dt_out, x.exp_dt);
   endtask

   task automatic apply_b(input vec_t x, input string nm);
      rst_b = x.rst; ib.r = x.r; ib.w = x.w; ib.nb = x.nb; ib.ad = x.ad; ib.dt_in = x.dt;
      @(posedge clk_sys); #1;
      check(nm, ib.ok, x.exp_ok, ib.dt_out, x.exp_dt);
   endtask

   initial begin
      drive_a(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
      ib.r = 1'b0; ib.w = 1'b0; ib.nb = 4'd0; ib.ad = 16'h0000; ib.dt_in = 16'h0000;

      // LAT=2 instance: write/read, abort, reset in WAIT and in ACK.
      va.push_back(v(0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 16'h0000)); // reset
      va.push_back(v(1, 0, 1, 4'd0, 16'h0010, 16'hbeef, 0, 16'h0000));
      va.push_back(v(1, 0, 1, 4'd0, 16'h0010, 16'hbeef, 0, 16'h0000));
      va.push_back(v(1, 0, 1, 4'd0, 16'h0010, 16'hbeef, 1, 16'h0000)); // write ack
      va.push_back(v(1, 0, 1, 4'd0, 16'h0010, 16'hbeef, 1, 16'h0000));
      va.push_back(v(1, 0, 0, 4'd0, 16'h0010, 16'hbeef, 0, 16'h0000)); // release
      va.push_back(v(1, 1, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0010, 16'h0000, 1, 16'hbeef)); // read ack
      va.push_back(v(1, 1, 0, 4'd0, 16'h0020, 16'h0000, 1, 16'hbeef)); // ad change ignored
      va.push_back(v(1, 0, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 0, 1, 4'd0, 16'h0020, 16'h0000, 0, 16'h0000)); // known content at 0x20
      va.push_back(v(1, 0, 1, 4'd0, 16'h0020, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 0, 1, 4'd0, 16'h0020, 16'h0000, 1, 16'h0000));
      va.push_back(v(1, 0, 0, 4'd0, 16'h0020, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 0, 1, 4'd0, 16'h0020, 16'h1234, 0, 16'h0000)); // aborted write
      va.push_back(v(1, 0, 0, 4'd0, 16'h0020, 16'h1234, 0, 16'h0000));
      va.push_back(v(1, 0, 0, 4'd0, 16'h0020, 16'h1234, 0, 16'h0000));
      va.push_back(v(1, 0, 0, 4'd0, 16'h0020, 16'h1234, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0020, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0020, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0020, 16'h0000, 1, 16'h0000)); // still old data
      va.push_back(v(1, 0, 0, 4'd0, 16'h0020, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 0, 1, 4'd0, 16'h0010, 16'haaaa, 0, 16'h0000)); // write enters WAIT
      va.push_back(v(0, 0, 1, 4'd0, 16'h0010, 16'haaaa, 0, 16'h0000)); // reset in WAIT
      va.push_back(v(1, 0, 0, 4'd0, 16'h0010, 16'haaaa, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000));
      va.push_back(v(1, 1, 0, 4'd0, 16'h0010, 16'h0000, 1, 16'hbeef)); // location unchanged
      va.push_back(v(0, 1, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000)); // reset in ACK
      va.push_back(v(1, 0, 0, 4'd0, 16'h0010, 16'h0000, 0, 16'h0000));

      foreach (va[i]) apply_a(va[i], $sformatf("lat2_vec%0d", i));

      // Both strobes high for 10 cycles: no ok, RAM untouched.
      for (int i = 0; i < 10; i++) begin
         drive_a(1'b1, 1'b1, 1'b1, 4'd0, 16'h0010, 16'h5555);
         @(posedge clk_sys); #1;
         check($sformatf("both_strobes_%0d", i), ia.ok, 1'b0, ia.dt_out, 16'h0000);
      end
      drive_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0000);
      @(posedge clk_sys); #1;
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b1, 1'b1, 1'b0, 4'd0, 16'h0010, 16'h0000);
         @(posedge clk_sys); #1;
      end
      check("both_strobes_ram", ia.ok, 1'b1, ia.dt_out, 16'hbeef);
      drive_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0000);
      @(posedge clk_sys); #1;
      check("both_strobes_release", ia.ok, 1'b0, ia.dt_out, 16'h0000);

      // Unmapped block number, then unmapped high address.
      for (int i = 0; i < 20; i++) begin
         drive_a(1'b1, 1'b0, 1'b1, 4'd3, 16'h0010, 16'h7777);
         @(posedge clk_sys); #1;
         check($sformatf("unmapped_nb_%0d", i), ia.ok, 1'b0, ia.dt_out, 16'h0000);
      end
      for (int i = 0; i < 20; i++) begin
         drive_a(1'b1, 1'b1, 1'b0, 4'd0, 16'hf000, 16'h0000);
         @(posedge clk_sys); #1;
         check($sformatf("unmapped_ad_%0d", i), ia.ok, 1'b0, ia.dt_out, 16'h0000);
      end
      drive_a(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);

      // LAT=0 instance: immediate ack, back-to-back reads, no second access in ACK.
      vb.push_back(v(0, 0, 0, 4'd0, 16'h0000, 16'h0000, 0, 16'h0000));
      vb.push_back(v(1, 0, 1, 4'd0, 16'h0001, 16'h1111, 1, 16'h0000));
      vb.push_back(v(1, 0, 0, 4'd0, 16'h0001, 16'h1111, 0, 16'h0000));
      vb.push_back(v(1, 0, 1, 4'd0, 16'h0002, 16'h2222, 1, 16'h0000));
      vb.push_back(v(1, 0, 0, 4'd0, 16'h0002, 16'h2222, 0, 16'h0000));
      vb.push_back(v(1, 1, 0, 4'd0, 16'h0001, 16'h0000, 1, 16'h1111));
      vb.push_back(v(1, 1, 0, 4'd0, 16'h0002, 16'h0000, 1, 16'h1111)); // held in ACK
      vb.push_back(v(1, 0, 0, 4'd0, 16'h0002, 16'h0000, 0, 16'h0000));
      vb.push_back(v(1, 1, 0, 4'd0, 16'h0002, 16'h0000, 1, 16'h2222));
      vb.push_back(v(1, 0, 0, 4'd0, 16'h0002, 16'h0000, 0, 16'h0000));

      foreach (vb[i]) apply_b(vb[i], $sformatf("lat0_vec%0d", i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
